bus_arbiter: RTL and testbench

Round-robin bus arbiter for the four bus masters on the shared bus. It drives the active-low grant lines that select which master's address, strobe, read/write and write data reach the shared slave side of the bus master multiplexer. Ownership is held while the owner keeps requesting. Each ownership change passes through one no-grant handover cycle. An optional hold limit forces ownership to rotate so that a single master cannot starve the others.

---
 rtl/bus_arbiter_if.sv | 19 +
 rtl/bus_arbiter.sv | 100 ++++++++++
 tb/tb_bus_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus master request/grant bundle between four bus masters and the arbiter.
// Every request and grant is active low. owner and switching are status
// outputs from the arbiter.
interface bus_arbiter_if;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       switching;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, switching
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, switching
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters with active-low request and grant
// lines. The owner keeps the bus while it requests. Every change of owner
// passes through one cycle in which no master is granted. When HOLD_MAX is
// nonzero, an owner that keeps requesting while others wait is preempted
// after HOLD_MAX granted cycles.
module bus_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input logic          clk,
  input logic          reset_,
  bus_arbiter_if.slave bus
);

  typedef enum logic {GRANT, SWITCH} state_t;

  // Last hold_cnt value at which the owner still keeps the bus
  localparam logic [CNT_W-1:0] HOLD_LIM =
    (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

  state_t           state, state_n;
  logic [1:0]       owner_q, owner_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic [3:0]       grnt_q, grnt_n;
  logic             sw_q, sw_n;

  logic [3:0] req;
  logic [3:0] others;
  logic [1:0] nxt;
  logic       hold_ok;

  assign req    = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  assign others = req & ~(4'b0001 << owner_q);

  assign bus.owner     = owner_q;
  assign bus.switching = sw_q;
  assign bus.m0_grnt_  = grnt_q[0];
  assign bus.m1_grnt_  = grnt_q[1];
  assign bus.m2_grnt_  = grnt_q[2];
  assign bus.m3_grnt_  = grnt_q[3];

  // Pick the first requesting non-owner in rotation order from the owner
  always_comb begin
    nxt = owner_q;
    for (int k = 3; k >= 1; k--)
      if (req[owner_q + 2'(k)]) nxt = owner_q + 2'(k);
  end

  // The owner may keep the bus if nobody waits, or if its hold budget remains
  assign hold_ok = (others == 4'b0000) || (HOLD_MAX == 0) || (hold_cnt < HOLD_LIM);

  // Choose the next state, owner and hold count, then decode the grant and status outputs
  always_comb begin
    state_n    = state;
    owner_n    = owner_q;
    hold_cnt_n = hold_cnt;
    case (state)
      GRANT: begin
        if (req[owner_q]) begin
          if (hold_ok) begin
            if (hold_cnt != '1) hold_cnt_n = hold_cnt + 1'b1;
          end else begin
            owner_n = nxt;
            state_n = SWITCH;
          end
        end else if (others != 4'b0000) begin
          owner_n = nxt;
          state_n = SWITCH;
        end else begin
          hold_cnt_n = '0;
        end
      end
      SWITCH: begin
        state_n    = GRANT;
        hold_cnt_n = '0;
      end
      default: state_n = GRANT;
    endcase
    grnt_n = (state_n == GRANT) ? ~(4'b0001 << owner_n) : 4'b1111;
    sw_n   = (state_n == SWITCH);
  end

  // State and output registers. Reset parks the bus on master 0.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state    <= GRANT;
      owner_q  <= 2'd0;
      hold_cnt <= '0;
      grnt_q   <= 4'b1110;
      sw_q     <= 1'b0;
    end else begin
      state    <= state_n;
      owner_q  <= owner_n;
      hold_cnt <= hold_cnt_n;
      grnt_q   <= grnt_n;
      sw_q     <= sw_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Drives three arbiters (HOLD_MAX 16, 4, 0) from one shared request pattern.
// Each arbiter is compared every cycle against a tenure-based reference
// model. A few directed scenarios are checked explicitly.
module tb_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic [3:0] req_n = 4'hF;
  int         n_vec = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  bus_arbiter_if ifa ();
  bus_arbiter_if ifb ();
  bus_arbiter_if ifc ();

  assign {ifa.m3_req_, ifa.m2_req_, ifa.m1_req_, ifa.m0_req_} = req_n;
  assign {ifb.m3_req_, ifb.m2_req_, ifb.m1_req_, ifb.m0_req_} = req_n;
  assign {ifc.m3_req_, ifc.m2_req_, ifc.m1_req_, ifc.m0_req_} = req_n;

  bus_arbiter #(.HOLD_MAX(16), .CNT_W(5)) u_a (.clk(clk), .reset_(reset_), .bus(ifa));
  bus_arbiter #(.HOLD_MAX(4),  .CNT_W(5)) u_b (.clk(clk), .reset_(reset_), .bus(ifb));
  bus_arbiter #(.HOLD_MAX(0),  .CNT_W(5)) u_c (.clk(clk), .reset_(reset_), .bus(ifc));

  // Reference model state: who holds the bus, whether it is in handover,
  // and how many granted cycles the owner has used while requesting.
  int hm[3] = '{16, 4, 0};
  int m_own[3];
  int m_sw[3];
  int m_ten[3];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d);
    int nxt;
    if (!reset_) begin
      m_own[d] = 0; m_sw[d] = 0; m_ten[d] = 0;
    end else if (m_sw[d] != 0) begin
      m_sw[d] = 0; m_ten[d] = 0;
    end else begin
      nxt = -1;
      for (int k = 1; k < 4; k++)
        if (nxt < 0 && !req_n[(m_own[d] + k) % 4]) nxt = (m_own[d] + k) % 4;
      if (!req_n[m_own[d]]) begin
        if (nxt < 0 || hm[d] == 0 || m_ten[d] + 1 < hm[d])
          m_ten[d] = (m_ten[d] < 31) ? m_ten[d] + 1 : 31;
        else begin
          m_own[d] = nxt; m_sw[d] = 1;
        end
      end else if (nxt >= 0) begin
        m_own[d] = nxt; m_sw[d] = 1;
      end else
        m_ten[d] = 0;
    end
  endtask

  function automatic int exp_grnt(input int d);
    return (m_sw[d] != 0) ? 15 : (15 & ~(1 << m_own[d]));
  endfunction

  // One clock: update the model with the inputs seen at the edge, then compare all three DUTs
  task automatic cyc();
    int g[3], o[3], s[3];
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    g[0] = {ifa.m3_grnt_, ifa.m2_grnt_, ifa.m1_grnt_, ifa.m0_grnt_};
    g[1] = {ifb.m3_grnt_, ifb.m2_grnt_, ifb.m1_grnt_, ifb.m0_grnt_};
    g[2] = {ifc.m3_grnt_, ifc.m2_grnt_, ifc.m1_grnt_, ifc.m0_grnt_};
    o[0] = ifa.owner; o[1] = ifb.owner; o[2] = ifc.owner;
    s[0] = ifa.switching; s[1] = ifb.switching; s[2] = ifc.switching;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("grnt[%0d]", d), g[d], exp_grnt(d));
      chk($sformatf("owner[%0d]", d), o[d], m_own[d]);
      chk($sformatf("switching[%0d]", d), s[d], m_sw[d]);
    end
  endtask

  initial begin
    int n;
    int got;
    // Reset followed by an idle bus: master 0 stays parked
    reset_ = 1'b0; req_n = 4'hF;
    cyc(); cyc();
    reset_ = 1'b1;
    repeat (5) cyc();
    chk("park_m0", {ifa.m3_grnt_, ifa.m2_grnt_, ifa.m1_grnt_, ifa.m0_grnt_}, 4'b1110);

    // Masters 0, 2 and 3 request. When master 0 releases, the bus goes to 2.
    req_n = 4'b0010;
    repeat (3) cyc();
    req_n = 4'b0011;
    cyc();
    chk("rel_switch", ifa.switching, 1);
    chk("rel_allhigh", {ifa.m3_grnt_, ifa.m2_grnt_, ifa.m1_grnt_, ifa.m0_grnt_}, 4'b1111);
    cyc();
    chk("rel_owner2", ifa.owner, 2);
    chk("rel_m2grnt", ifa.m2_grnt_, 0);

    // Park on 2, hand over to 1, then contend 1 against 2
    req_n = 4'hF; cyc(); cyc();
    req_n = 4'b1101; cyc(); cyc();
    chk("m1_granted", ifb.m1_grnt_, 0);
    req_n = 4'b1001;
    n = (ifb.m1_grnt_ == 1'b0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (ifb.switching) break;
      if (!ifb.m1_grnt_) n++;
    end
    chk("hold4_cycles", n, 4);
    chk("hold0_keeps", ifc.owner, 1);
    chk("hold0_grnt", ifc.m1_grnt_, 0);

    // Owner 1 on the HOLD_MAX=16 arbiter releases toward 2. Reset lands in the handover.
    req_n = 4'b1011;
    got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin
      cyc();
      if (ifa.switching) got = 1;
    end
    chk("reach_switch", got, 1);
    chk("switch_to2", ifa.owner, 2);
    reset_ = 1'b0;
    cyc();
    chk("rst_owner", ifa.owner, 0);
    chk("rst_sw", ifa.switching, 0);
    chk("rst_grnt", {ifa.m3_grnt_, ifa.m2_grnt_, ifa.m1_grnt_, ifa.m0_grnt_}, 4'b1110);
    reset_ = 1'b1;

    // Random request traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) req_n[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(15) == 0) req_n = 4'($urandom);
      reset_ = ($urandom_range(299) != 0);
      cyc();
    end
    reset_ = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
